// File: rtl/mbox_mem_ctl.sv
// EBOX memory controller: req/ack handshake in front of an inferred word RAM,
// with configurable wait states and a nonexistent-memory flag for addresses beyond DEPTH.
module mbox_mem_ctl #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DEPTH       = 4096,
   parameter int unsigned DATA_W      = 36,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              mboxClk,
   input  logic              mboxReset,
   input  logic [13:35]      EBOX_VMA,
   input  logic [DATA_W-1:0] cacheDataWrite,
   input  logic              req,
   input  logic              read,
   input  logic              write,
   output logic              busy,
   output logic              ack,
   output logic              nxm,
   output logic [DATA_W-1:0] cacheDataRead
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RAM_AW-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                op_wr_q, oor_q;
   logic                busy_d, ack_d, nxm_d;
   logic                accept_c, ram_we_c, rd_load_c, req_ok_c, oor_c;
   logic [ADDR_W-1:0]   vma_addr_c;
   logic                unused_vma_c;
   logic [DATA_W-1:0]   ram [DEPTH];

   // Word address is the low ADDR_W bits of the VMA (bit 35 is the LSB).
   assign vma_addr_c   = EBOX_VMA[36-ADDR_W:35];
   assign oor_c        = 32'(vma_addr_c) >= DEPTH;
   assign req_ok_c     = req & (read ^ write);
   assign unused_vma_c = ^EBOX_VMA;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy;
      ack_d     = 1'b0;
      nxm_d     = 1'b0;
      accept_c  = 1'b0;
      ram_we_c  = 1'b0;
      rd_load_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (req_ok_c) begin
               accept_c = 1'b1;
               cnt_d    = CNT_W'(WAIT_STATES);
               busy_d   = 1'b1;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            busy_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Gating on reset keeps an edge coincident with reset from committing.
               ram_we_c  = op_wr_q & ~oor_q & ~mboxReset;
               rd_load_c = ~op_wr_q;
               ack_d     = 1'b1;
               nxm_d     = oor_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge mboxClk or posedge mboxReset) begin
      if (mboxReset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         busy          <= 1'b0;
         ack           <= 1'b0;
         nxm           <= 1'b0;
         cacheDataRead <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         op_wr_q       <= 1'b0;
         oor_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= busy_d;
         ack     <= ack_d;
         nxm     <= nxm_d;
         if (accept_c) begin
            addr_q  <= vma_addr_c[RAM_AW-1:0];
            wdata_q <= cacheDataWrite;
            op_wr_q <= write;
            oor_q   <= oor_c;
         end
         if (rd_load_c) begin
            cacheDataRead <= oor_q ? '0 : ram[addr_q];
         end
      end
   end

   // Single-port word RAM; contents are deliberately not reset.
   always_ff @(posedge mboxClk) begin
      if (ram_we_c) begin
         ram[addr_q] <= wdata_q;
      end
   end

`ifndef SYNTHESIS
   always @(posedge mboxClk) begin
      if (!mboxReset && state_q == IDLE && req && !(read ^ write)) begin
         $warning("mbox_mem_ctl: illegal request ignored, read=%0b write=%0b", read, write);
      end
   end
`endif

endmodule

// File: tb/tb_mbox_mem_ctl.sv
// Directed bench for mbox_mem_ctl: three instances cover WAIT_STATES=2, WAIT_STATES=0
// and a half-populated address space (DEPTH=2048).
module tb_mbox_mem_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:35] vma = '0;
   logic [35:0] wdata = '0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic        req_v   [3];
   logic        busy_v  [3];
   logic        ack_v   [3];
   logic        nxm_v   [3];
   logic [35:0] rdata_v [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mbox_mem_ctl #(.ADDR_W(12), .DEPTH(4096), .DATA_W(36), .WAIT_STATES(2)) u_ws2 (
      .mboxClk(clk), .mboxReset(rst), .EBOX_VMA(vma), .cacheDataWrite(wdata),
      .req(req_v[0]), .read(rd_en), .write(wr_en),
      .busy(busy_v[0]), .ack(ack_v[0]), .nxm(nxm_v[0]), .cacheDataRead(rdata_v[0]));

   mbox_mem_ctl #(.ADDR_W(12), .DEPTH(4096), .DATA_W(36), .WAIT_STATES(0)) u_ws0 (
      .mboxClk(clk), .mboxReset(rst), .EBOX_VMA(vma), .cacheDataWrite(wdata),
      .req(req_v[1]), .read(rd_en), .write(wr_en),
      .busy(busy_v[1]), .ack(ack_v[1]), .nxm(nxm_v[1]), .cacheDataRead(rdata_v[1]));

   mbox_mem_ctl #(.ADDR_W(12), .DEPTH(2048), .DATA_W(36), .WAIT_STATES(2)) u_d2k (
      .mboxClk(clk), .mboxReset(rst), .EBOX_VMA(vma), .cacheDataWrite(wdata),
      .req(req_v[2]), .read(rd_en), .write(wr_en),
      .busy(busy_v[2]), .ack(ack_v[2]), .nxm(nxm_v[2]), .cacheDataRead(rdata_v[2]));

   // Drive a request at a falling edge; returns at the falling edge after the acceptance edge.
   task automatic issue(input int sel, input bit wr, input logic [22:0] a, input logic [35:0] d);
      @(negedge clk);
      vma = a; wdata = d; rd_en = !wr; wr_en = wr; req_v[sel] = 1'b1;
      @(negedge clk);
   endtask

   // lat is the number of the cycle after acceptance in which ack is seen (1-based), -1 on timeout.
   task automatic wait_ack(input int sel, output int lat, output logic n, output logic [35:0] rd);
      lat = -1; n = 1'b0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         if (ack_v[sel] === 1'b1) begin
            lat = i; n = nxm_v[sel]; rd = rdata_v[sel];
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic access(input int sel, input bit wr, input logic [22:0] a, input logic [35:0] d,
                         output int lat, output logic n, output logic [35:0] rd);
      issue(sel, wr, a, d);
      req_v[sel] = 1'b0;
      wait_ack(sel, lat, n, rd);
   endtask

   task automatic test_reset;
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
      checks++; if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_v[0]); end
      checks++; if (nxm_v[0] !== 1'b0) begin errors++; $display("FAIL reset_nxm: got %b want 0", nxm_v[0]); end
      checks++; if (rdata_v[0] !== 36'd0) begin errors++; $display("FAIL reset_rdata: got %o want 0", rdata_v[0]); end
   endtask

   task automatic test_basic;
      int lat; logic n; logic [35:0] rd;
      access(0, 1'b1, 23'o100, 36'o123456_701234, lat, n, rd);
      checks++; if (lat != 4) begin errors++; $display("FAIL basic_wr_lat: got %0d want 4", lat); end
      checks++; if (n !== 1'b0) begin errors++; $display("FAIL basic_wr_nxm: got %b want 0", n); end
      access(0, 1'b0, 23'o100, 36'o0, lat, n, rd);
      checks++; if (lat != 4) begin errors++; $display("FAIL basic_rd_lat: got %0d want 4", lat); end
      checks++; if (n !== 1'b0) begin errors++; $display("FAIL basic_rd_nxm: got %b want 0", n); end
      checks++; if (rd !== 36'o123456701234) begin errors++; $display("FAIL basic_rd_data: got %o want 123456701234", rd); end
   endtask

   task automatic test_zero_wait;
      int lat; logic n; logic [35:0] rd;
      access(1, 1'b1, 23'o7777, 36'o777777777777, lat, n, rd);
      checks++; if (lat != 2) begin errors++; $display("FAIL ws0_wr_lat: got %0d want 2", lat); end
      access(1, 1'b0, 23'o7777, 36'o0, lat, n, rd);
      checks++; if (lat != 2) begin errors++; $display("FAIL ws0_rd_lat: got %0d want 2", lat); end
      checks++; if (rd !== 36'o777777777777) begin errors++; $display("FAIL ws0_rd_data: got %o want 777777777777", rd); end
   endtask

   task automatic test_nxm;
      int lat; logic n; logic [35:0] rd;
      access(2, 1'b1, 23'o3777, 36'o111111222222, lat, n, rd);
      access(2, 1'b1, 23'o0, 36'o333333444444, lat, n, rd);
      access(2, 1'b0, 23'o3777, 36'o0, lat, n, rd);
      checks++; if (rd !== 36'o111111222222) begin errors++; $display("FAIL nxm_pre_rd: got %o want 111111222222", rd); end
      access(2, 1'b1, 23'o4000, 36'o555555666666, lat, n, rd);
      checks++; if (lat != 4) begin errors++; $display("FAIL nxm_wr_lat: got %0d want 4", lat); end
      checks++; if (n !== 1'b1) begin errors++; $display("FAIL nxm_wr_flag: got %b want 1", n); end
      checks++; if (rd !== 36'o111111222222) begin errors++; $display("FAIL nxm_wr_keeps_rdata: got %o want 111111222222", rd); end
      access(2, 1'b0, 23'o4000, 36'o0, lat, n, rd);
      checks++; if (n !== 1'b1) begin errors++; $display("FAIL nxm_rd_flag: got %b want 1", n); end
      checks++; if (rd !== 36'd0) begin errors++; $display("FAIL nxm_rd_data: got %o want 0", rd); end
      access(2, 1'b0, 23'o3777, 36'o0, lat, n, rd);
      checks++; if (n !== 1'b0) begin errors++; $display("FAIL nxm_edge_flag: got %b want 0", n); end
      checks++; if (rd !== 36'o111111222222) begin errors++; $display("FAIL nxm_edge_data: got %o want 111111222222", rd); end
      access(2, 1'b0, 23'o0, 36'o0, lat, n, rd);
      checks++; if (rd !== 36'o333333444444) begin errors++; $display("FAIL nxm_alias_data: got %o want 333333444444", rd); end
   endtask

   task automatic test_back_to_back;
      int lat; logic n; logic [35:0] rd;
      issue(0, 1'b1, 23'o300, 36'o101010101010);
      vma = 23'o301; wdata = 36'o202020202020;
      wait_ack(0, lat, n, rd);
      checks++; if (lat != 4) begin errors++; $display("FAIL b2b_first_lat: got %0d want 4", lat); end
      @(negedge clk);
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy_v[0]); end
      @(negedge clk);
      checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b want 1", busy_v[0]); end
      req_v[0] = 1'b0;
      wait_ack(0, lat, n, rd);
      checks++; if (lat != 4) begin errors++; $display("FAIL b2b_second_lat: got %0d want 4", lat); end
      access(0, 1'b0, 23'o300, 36'o0, lat, n, rd);
      checks++; if (rd !== 36'o101010101010) begin errors++; $display("FAIL b2b_orig_data: got %o want 101010101010", rd); end
      access(0, 1'b0, 23'o301, 36'o0, lat, n, rd);
      checks++; if (rd !== 36'o202020202020) begin errors++; $display("FAIL b2b_second_data: got %o want 202020202020", rd); end
   endtask

   task automatic test_reset_abort;
      int lat; logic n; logic [35:0] rd;
      bit saw_ack;
      access(0, 1'b1, 23'o200, 36'd5, lat, n, rd);
      issue(0, 1'b1, 23'o200, 36'd7);
      req_v[0] = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_v[0]); end
      checks++; if (rdata_v[0] !== 36'd0) begin errors++; $display("FAIL abort_rdata: got %o want 0", rdata_v[0]); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      saw_ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ack_v[0] !== 1'b0) saw_ack = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw_ack) begin errors++; $display("FAIL abort_no_ack: got ack want none"); end
      access(0, 1'b0, 23'o200, 36'o0, lat, n, rd);
      checks++; if (rd !== 36'd5) begin errors++; $display("FAIL abort_ram_kept: got %o want 5", rd); end
   endtask

   task automatic test_illegal;
      @(negedge clk);
      vma = 23'o100; rd_en = 1'b1; wr_en = 1'b1; req_v[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (busy_v[0] !== 1'b0 || ack_v[0] !== 1'b0) begin
            errors++; $display("FAIL illegal_both cycle %0d: busy=%b ack=%b want 0 0", i, busy_v[0], ack_v[0]);
         end
      end
      rd_en = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (busy_v[0] !== 1'b0 || ack_v[0] !== 1'b0) begin
            errors++; $display("FAIL illegal_none cycle %0d: busy=%b ack=%b want 0 0", i, busy_v[0], ack_v[0]);
         end
      end
      req_v[0] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
      #1;
      test_reset;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_basic;
      test_zero_wait;
      test_nxm;
      test_back_to_back;
      test_reset_abort;
      test_illegal;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mbox_mem_ctl.md
Name: mbox_mem_ctl

Overview:
Parametrised successor to the single-cycle fake-memory MBOX. It accepts EBOX memory requests through a req/ack handshake and inserts a configurable number of wait states before completing each access. Addresses beyond the implemented depth complete with a nonexistent-memory (NXM) flag. It sits between the EBOX VMA/data paths and an inferred synchronous word RAM.

Parameters:
ADDR_W, 12, number of low VMA bits used as the word address (bits [36-ADDR_W:35] of the VMA).
DEPTH, 4096, implemented words; must satisfy DEPTH <= 2**ADDR_W.
DATA_W, 36, word width.
WAIT_STATES, 2, extra cycles between request acceptance and ack; range 0..15.

Ports:
mboxClk  in  1  clock; all state changes on the rising edge.
mboxReset  in  1  asynchronous, active-high reset.
EBOX_VMA  in  23 ([13:35])  request address; sampled only on acceptance.
cacheDataWrite  in  DATA_W  write data; sampled on acceptance.
req  in  1  request strobe; level-sensitive, held until ack.
read  in  1  read request qualifier.
write  in  1  write request qualifier.
busy  out  1  high while an access is in progress (ACCESS or DONE).
ack  out  1  one-cycle completion pulse.
nxm  out  1  one-cycle pulse coincident with ack when the address is >= DEPTH.
cacheDataRead  out  DATA_W  read data; valid in the ack cycle and held until the next accepted read.

Behaviour:
- Reset (asynchronous): state=IDLE, busy=0, ack=0, nxm=0, cacheDataRead=0, wait counter=0. RAM contents are not reset.
- Reset asserted mid-access aborts the access. An in-flight write must not modify RAM if reset asserts before the commit edge.
- Address: addr = EBOX_VMA[36-ADDR_W:35]. The access is out of range when addr >= DEPTH.
- FSM IDLE:
  - If req=1 and exactly one of read/write is 1, accept the request.
  - On acceptance, latch addr, op, and data, and compute the out-of-range flag. Then set cnt=WAIT_STATES, busy=1, and go to ACCESS.
  - If req=1 with read=write=0 or read=write=1, the request is illegal. Stay in IDLE, raise no ack, and log an error in simulation only.
- FSM ACCESS:
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - A write commits to RAM on this edge unless the address is out of range.
    - A read registers RAM data into cacheDataRead, or all-zeros if out of range.
    - Go to DONE.
- FSM DONE:
  - ack=1 for this cycle only, with nxm=1 if out of range. busy=1.
  - Next state is IDLE.
- Latency from the acceptance edge to the ack cycle is WAIT_STATES+2 cycles. With WAIT_STATES=0: accept at edge N, ack is high during the cycle after edge N+1.
- Back-to-back accesses: the cycle after DONE is IDLE. If the requester still holds req, that request is accepted as a new access, so the requester must drop req in the ack cycle. Minimum issue interval is WAIT_STATES+3 cycles.
- Inputs are ignored while busy. Changes to EBOX_VMA, data, read or write after acceptance have no effect on the current access.
- Reads return RAM contents as of the commit edge, so a write followed by a read of the same address returns the new data.
- cacheDataRead is unchanged by writes and by NXM writes.
- The RAM is inferred as a DEPTH x DATA_W synchronous array with one read/write port.

Test Plan:
1. Reset with WAIT_STATES=2 -> busy=0, ack=0, nxm=0, cacheDataRead=0. Write 36'o123456_701234 to VMA 0o100, then read 0o100 -> ack 4 cycles after each acceptance, nxm=0, cacheDataRead=36'o123456701234.
2. WAIT_STATES=0: write then read 0o7777 holding 36'o777777777777 -> ack on the 2nd cycle after acceptance; read data matches.
3. DEPTH=2048, ADDR_W=12: write to 0o4000, then read 0o4000 -> nxm=1 with ack on both accesses; read data=0. Read of 0o3777 still returns its prior value, i.e. RAM is unchanged.
4. Change VMA and cacheDataWrite during ACCESS -> the original address and data are committed. Hold req through ack -> a second access starts the cycle after DONE.
5. Assert mboxReset during ACCESS of a write to 0o200 (old value 5, new value 7) -> outputs clear immediately, no ack, and a subsequent read of 0o200 returns 5.
6. req=1 with read=write=1 -> busy stays 0 and no ack for 10 cycles.
